// File: rtl/wb_conv_master.sv
// Wishbone classic initiator that moves N-beat write/read block transfers between
// local streams and the conv accelerator slave bus, one non-pipelined beat at a time.
module wb_conv_master #(
    parameter int LEN_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_WIDTH       = 7
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [31:0]          cmd_adr,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic [31:0]          wr_dat,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    output logic [31:0]          rd_dat,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic [3:0]           wbm_sel_o,
    output logic [31:0]          wbm_adr_o,
    output logic [31:0]          wbm_dat_o,
    input  logic                 wbm_ack_i,
    input  logic [31:0]          wbm_dat_i,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_BUS,
        S_HOLD,
        S_FIN
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_we;
    logic [31:0]            r_adr;
    logic [LEN_WIDTH-1:0]   r_rem;
    logic [TO_WIDTH-1:0]    r_to;
    logic                   r_cyc;
    logic                   r_stb;
    logic                   r_wbm_we;
    logic [3:0]             r_sel;
    logic [31:0]            r_dat_o;
    logic [31:0]            r_rd_dat;
    logic                   r_rd_valid;
    logic                   r_done;
    logic                   r_err;
    logic                   w_ack;
    logic                   w_expire;
    logic                   w_bus_next;
    logic                   w_we_eff;

    // Ack only counts while our strobe is up; stray acks are ignored.
    assign w_ack      = wbm_ack_i & r_stb;
    assign w_expire   = (r_state == S_BUS) && !w_ack &&
                        (r_to == TO_WIDTH'(TIMEOUT_CYCLES - 1));
    assign w_bus_next = (w_state_next == S_BUS);
    // IDLE->BUS latches the direction on the same edge, so take it from the command.
    assign w_we_eff   = (r_state == S_IDLE) ? cmd_we : r_we;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        w_state_next = S_FIN;
                    end else if (cmd_we) begin
                        w_state_next = S_FETCH;
                    end else begin
                        w_state_next = S_BUS;
                    end
                end
            end
            S_FETCH: begin
                if (wr_valid) begin
                    w_state_next = S_BUS;
                end
            end
            S_BUS: begin
                if (w_ack) begin
                    if (!r_we) begin
                        w_state_next = S_HOLD;
                    end else if (r_rem == LEN_WIDTH'(1)) begin
                        w_state_next = S_FIN;
                    end else begin
                        w_state_next = S_FETCH;
                    end
                end else if (w_expire) begin
                    w_state_next = S_IDLE;
                end
            end
            S_HOLD: begin
                if (rd_ready) begin
                    w_state_next = (r_rem != '0) ? S_BUS : S_FIN;
                end
            end
            S_FIN: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_we       <= 1'b0;
            r_adr      <= '0;
            r_rem      <= '0;
            r_to       <= '0;
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
            r_wbm_we   <= 1'b0;
            r_sel      <= 4'h0;
            r_dat_o    <= '0;
            r_rd_dat   <= '0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            // Bus strobes are registered copies of "next state is BUS".
            r_cyc    <= w_bus_next;
            r_stb    <= w_bus_next;
            r_wbm_we <= w_bus_next & w_we_eff;
            r_sel    <= w_bus_next ? 4'hF : 4'h0;
            r_to     <= ((r_state == S_BUS) && w_bus_next) ? r_to + TO_WIDTH'(1) : '0;
            r_done   <= (r_state == S_FIN);
            r_err    <= w_expire;
            if ((r_state == S_IDLE) && cmd_valid) begin
                r_we  <= cmd_we;
                r_adr <= cmd_adr;
                r_rem <= cmd_len;
            end
            if ((r_state == S_FETCH) && wr_valid) begin
                r_dat_o <= wr_dat;
            end
            if (w_ack) begin
                r_adr <= r_adr + 32'd4;
                r_rem <= r_rem - LEN_WIDTH'(1);
                if (!r_we) begin
                    r_rd_dat   <= wbm_dat_i;
                    r_rd_valid <= 1'b1;
                end
            end
            if ((r_state == S_HOLD) && rd_ready) begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign wr_ready  = (r_state == S_FETCH);
    assign busy      = (r_state != S_IDLE);
    assign rd_dat    = r_rd_dat;
    assign rd_valid  = r_rd_valid;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_stb;
    assign wbm_we_o  = r_wbm_we;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat_o;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_wb_conv_master.sv
// Self-checking bench for wb_conv_master: a behavioural slave with a programmable
// ack, a bus monitor feeding an observed-beat queue, and per-scenario test tasks.
`timescale 1ns/1ps
module tb_wb_conv_master;

    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [7:0]  run;
        logic        cyc;
    } beat_t;

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [7:0]  cmd_len = '0;
    logic [31:0] wr_dat = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] rd_dat;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i = 1'b0;
    logic [31:0] wbm_dat_i = '0;
    logic        busy, done, err;

    int n_cmp = 0;
    int n_err = 0;

    // monitor / slave state
    beat_t       obs_q[$];
    beat_t       exp_q[$];
    logic [31:0] slave_dat_q[$];
    logic [31:0] wr_words[$];
    logic [31:0] rd_got_q[$];
    logic [31:0] exp_rd_q[$];
    bit          slave_en = 1'b1;
    int          ack_wait = 0;
    int          run_len = 0;
    int          last_run = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          cyc_cnt = 0;
    int          overlap_cnt = 0;
    int          rd_unstable = 0;

    always #5 clk = ~clk;

    wb_conv_master #(.LEN_WIDTH(8), .TIMEOUT_CYCLES(64), .TO_WIDTH(7)) dut (
        .wb_clk_i (clk),        .wb_rst_i (wb_rst_i),
        .cmd_valid(cmd_valid),  .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),     .cmd_adr  (cmd_adr),   .cmd_len(cmd_len),
        .wr_dat   (wr_dat),     .wr_valid (wr_valid),  .wr_ready(wr_ready),
        .rd_dat   (rd_dat),     .rd_valid (rd_valid),  .rd_ready(rd_ready),
        .wbm_cyc_o(wbm_cyc_o),  .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o),  .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i),  .wbm_dat_i(wbm_dat_i),
        .busy     (busy),       .done     (done),      .err(err)
    );

    // Slave: acks one full cycle after it first sees the strobe.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (wbm_stb_o && !wbm_ack_i && slave_en) begin
                if (ack_wait >= 1) begin
                    wbm_ack_i = 1'b1;
                    if (slave_dat_q.size() > 0) wbm_dat_i = slave_dat_q.pop_front();
                    else wbm_dat_i = 32'hDEAD_BEEF;
                    ack_wait = 0;
                end else begin
                    ack_wait++;
                end
            end else begin
                wbm_ack_i = 1'b0;
                ack_wait = 0;
            end
        end
    end

    // Monitor: records each completed beat with the length of its strobe run.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (wbm_cyc_o) cyc_cnt++;
            if (wbm_stb_o && rd_valid) overlap_cnt++;
            if (wbm_stb_o) begin
                run_len++;
                last_run = run_len;
                if (wbm_ack_i) begin
                    b.adr = wbm_adr_o;
                    b.we  = wbm_we_o;
                    b.sel = wbm_sel_o;
                    b.dat = wbm_we_o ? wbm_dat_o : 32'h0;
                    b.run = 8'(run_len);
                    b.cyc = wbm_cyc_o;
                    obs_q.push_back(b);
                end
            end else begin
                run_len = 0;
            end
        end
    end

    function automatic beat_t mk_beat(input logic [31:0] adr, input logic we, input logic [31:0] dat);
        beat_t b;
        b.adr = adr;
        b.we  = we;
        b.sel = 4'hF;
        b.dat = we ? dat : 32'h0;
        b.run = 8'd2;
        b.cyc = 1'b1;
        return b;
    endfunction

    task automatic issue_cmd(input logic we, input logic [31:0] adr, input logic [7:0] len);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_len   = len;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Drives the write/read streams until the DUT returns to IDLE or the budget runs out.
    task automatic run_xfer(input int wr_gap, input int rd_wait, input int limit,
                            output int ncyc, output bit ok,
                            output logic done_e, output logic err_e, output logic rdy_e);
        int idx = 0;
        int hold = 0;
        logic [31:0] held = '0;
        ncyc = 0;
        ok = 1'b0;
        while (ncyc < limit) begin
            @(negedge clk);
            ncyc++;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            wr_valid = (idx < wr_words.size()) && ((ncyc % wr_gap) == 0);
            wr_dat   = wr_valid ? wr_words[idx] : 32'h0;
            if (wr_valid && wr_ready) idx++;
            if (rd_valid) begin
                if (hold > 0 && rd_dat !== held) rd_unstable++;
                held = rd_dat;
                hold++;
                rd_ready = (hold > rd_wait);
                if (rd_ready) begin
                    rd_got_q.push_back(rd_dat);
                    hold = 0;
                end
            end else begin
                rd_ready = 1'b0;
                hold = 0;
            end
        end
        done_e = done;
        err_e  = err;
        rdy_e  = cmd_ready;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cmd_ready, busy, wbm_cyc_o, wbm_stb_o, wbm_we_o, wr_ready, rd_valid, done, err} !== 9'b100000000) begin
            n_err++;
            $display("FAIL reset_flags got=%b want=100000000",
                     {cmd_ready, busy, wbm_cyc_o, wbm_stb_o, wbm_we_o, wr_ready, rd_valid, done, err});
        end
        n_cmp++;
        if ({wbm_sel_o, wbm_adr_o, wbm_dat_o, rd_dat} !== 100'h0) begin
            n_err++;
            $display("FAIL reset_data got sel=%h adr=%h dat=%h rd=%h want all 0", wbm_sel_o, wbm_adr_o, wbm_dat_o, rd_dat);
        end
        wb_rst_i = 1'b0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_write_burst();
        int ncyc; bit ok; logic de, ee, re;
        int d0 = done_cnt;
        beat_t e, o;
        wr_words = '{32'h11, 32'h22, 32'h33};
        for (int i = 0; i < 3; i++) exp_q.push_back(mk_beat(32'h3000_0010 + 32'(4 * i), 1'b1, wr_words[i]));
        issue_cmd(1'b1, 32'h3000_0010, 8'd3);
        run_xfer(1, 0, 100, ncyc, ok, de, ee, re);
        n_cmp++;
        if (!ok || de !== 1'b1) begin
            n_err++;
            $display("FAIL wr_burst_end ok=%0d done_at_idle=%b want ok=1 done=1", ok, de);
        end
        n_cmp++;
        if (done_cnt - d0 != 1) begin
            n_err++;
            $display("FAIL wr_burst_done_count got=%0d want=1", done_cnt - d0);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL wr_burst_beats got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL wr_burst_beat got=%h want=%h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
        $display("test_write_burst cycles=%0d", ncyc);
    endtask

    task automatic test_read_backpressure();
        int ncyc; bit ok; logic de, ee, re;
        int ov0 = overlap_cnt;
        beat_t e, o;
        logic [31:0] ed;
        rd_unstable = 0;
        rd_got_q.delete();
        wr_words.delete();
        slave_dat_q = '{32'hA5A5_A5A5, 32'h5A5A_5A5A};
        exp_rd_q    = '{32'hA5A5_A5A5, 32'h5A5A_5A5A};
        exp_q.push_back(mk_beat(32'h3200_0000, 1'b0, 32'h0));
        exp_q.push_back(mk_beat(32'h3200_0004, 1'b0, 32'h0));
        issue_cmd(1'b0, 32'h3200_0000, 8'd2);
        run_xfer(1, 3, 100, ncyc, ok, de, ee, re);
        n_cmp++;
        if (!ok || de !== 1'b1) begin
            n_err++;
            $display("FAIL rd_end ok=%0d done_at_idle=%b want ok=1 done=1", ok, de);
        end
        n_cmp++;
        if (rd_unstable != 0 || overlap_cnt != ov0) begin
            n_err++;
            $display("FAIL rd_hold unstable=%0d stb_during_hold=%0d want 0/0", rd_unstable, overlap_cnt - ov0);
        end
        n_cmp++;
        if (rd_got_q.size() != exp_rd_q.size()) begin
            n_err++;
            $display("FAIL rd_count got=%0d want=%0d", rd_got_q.size(), exp_rd_q.size());
        end
        while (exp_rd_q.size() > 0 && rd_got_q.size() > 0) begin
            ed = exp_rd_q.pop_front();
            n_cmp++;
            if (rd_got_q[0] !== ed) begin
                n_err++;
                $display("FAIL rd_data got=%h want=%h", rd_got_q[0], ed);
            end
            void'(rd_got_q.pop_front());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL rd_beat got=%h want=%h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete(); exp_rd_q.delete(); rd_got_q.delete();
        $display("test_read_backpressure cycles=%0d", ncyc);
    endtask

    task automatic test_write_gapped();
        int ncyc; bit ok; logic de, ee, re;
        beat_t e, o;
        wr_words = '{32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003};
        for (int i = 0; i < 3; i++) exp_q.push_back(mk_beat(32'h3100_0040 + 32'(4 * i), 1'b1, wr_words[i]));
        issue_cmd(1'b1, 32'h3100_0040, 8'd3);
        run_xfer(4, 0, 200, ncyc, ok, de, ee, re);
        n_cmp++;
        if (!ok || de !== 1'b1) begin
            n_err++;
            $display("FAIL wr_gap_end ok=%0d done_at_idle=%b want ok=1 done=1", ok, de);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL wr_gap_beats got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL wr_gap_beat got=%h want=%h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete(); wr_words.delete();
        $display("test_write_gapped cycles=%0d", ncyc);
    endtask

    task automatic test_timeout();
        int ncyc; bit ok; logic de, ee, re;
        int d0 = done_cnt;
        int e0 = err_cnt;
        beat_t e, o;
        slave_en = 1'b0;
        issue_cmd(1'b0, 32'h3300_0000, 8'd3);
        run_xfer(1, 0, 300, ncyc, ok, de, ee, re);
        n_cmp++;
        if (!ok || ee !== 1'b1 || de !== 1'b0 || re !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_end ok=%0d err=%b done=%b cmd_ready=%b want 1/1/0/1", ok, ee, de, re);
        end
        n_cmp++;
        if (last_run != 64) begin
            n_err++;
            $display("FAIL timeout_stb_cycles got=%0d want=64", last_run);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (err_cnt - e0 != 1 || done_cnt != d0 || obs_q.size() != 0) begin
            n_err++;
            $display("FAIL timeout_pulses err=%0d done=%0d beats=%0d want 1/0/0", err_cnt - e0, done_cnt - d0, obs_q.size());
        end
        slave_en = 1'b1;
        slave_dat_q = '{32'h1234_5678};
        exp_q.push_back(mk_beat(32'h3300_0000, 1'b0, 32'h0));
        issue_cmd(1'b0, 32'h3300_0000, 8'd1);
        run_xfer(1, 0, 100, ncyc, ok, de, ee, re);
        n_cmp++;
        if (!ok || de !== 1'b1 || rd_got_q.size() != 1) begin
            n_err++;
            $display("FAIL after_timeout_end ok=%0d done=%b reads=%0d want 1/1/1", ok, de, rd_got_q.size());
        end else begin
            n_cmp++;
            if (rd_got_q[0] !== 32'h1234_5678) begin
                n_err++;
                $display("FAIL after_timeout_data got=%h want=12345678", rd_got_q[0]);
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL after_timeout_beat got=%h want=%h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete(); rd_got_q.delete();
        $display("test_timeout stb_cycles=%0d", last_run);
    endtask

    task automatic test_len_zero();
        int ncyc; bit ok; logic de, ee, re;
        int c0 = cyc_cnt;
        issue_cmd(1'b1, 32'h3000_0000, 8'd0);
        run_xfer(1, 0, 20, ncyc, ok, de, ee, re);
        n_cmp++;
        if (!ok || ncyc != 2 || de !== 1'b1) begin
            n_err++;
            $display("FAIL len0_done ok=%0d cycles=%0d done=%b want 1/2/1", ok, ncyc, de);
        end
        n_cmp++;
        if (cyc_cnt != c0 || obs_q.size() != 0) begin
            n_err++;
            $display("FAIL len0_bus cyc_cycles=%0d beats=%0d want 0/0", cyc_cnt - c0, obs_q.size());
        end
        $display("test_len_zero cycles=%0d", ncyc);
    endtask

    task automatic test_addr_wrap();
        int ncyc; bit ok; logic de, ee, re;
        beat_t e, o;
        wr_words = '{32'hAAAA_0001, 32'hAAAA_0002};
        exp_q.push_back(mk_beat(32'hFFFF_FFFC, 1'b1, 32'hAAAA_0001));
        exp_q.push_back(mk_beat(32'h0000_0000, 1'b1, 32'hAAAA_0002));
        issue_cmd(1'b1, 32'hFFFF_FFFC, 8'd2);
        run_xfer(1, 0, 100, ncyc, ok, de, ee, re);
        n_cmp++;
        if (!ok || obs_q.size() != 2) begin
            n_err++;
            $display("FAIL wrap_end ok=%0d beats=%0d want 1/2", ok, obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL wrap_beat got=%h want=%h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete(); wr_words.delete();
        $display("test_addr_wrap cycles=%0d", ncyc);
    endtask

    task automatic test_reset_mid_read();
        int ncyc; bit ok; logic de, ee, re;
        bit found = 1'b0;
        int d0, e0;
        beat_t e, o;
        slave_dat_q = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004};
        issue_cmd(1'b0, 32'h3100_0100, 8'd4);
        rd_ready = 1'b1;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (obs_q.size() >= 1 && wbm_stb_o) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL rst_mid_wait got=no_second_stb want=second_stb");
        end
        d0 = done_cnt;
        e0 = err_cnt;
        wb_rst_i = 1'b1;
        rd_ready = 1'b0;
        #1;
        n_cmp++;
        if ({wbm_cyc_o, wbm_stb_o, rd_valid, busy, cmd_ready} !== 5'b00001) begin
            n_err++;
            $display("FAIL rst_mid_outputs got=%b want=00001", {wbm_cyc_o, wbm_stb_o, rd_valid, busy, cmd_ready});
        end
        repeat (2) @(negedge clk);
        wb_rst_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (done_cnt != d0 || err_cnt != e0) begin
            n_err++;
            $display("FAIL rst_mid_pulses done=%0d err=%0d want 0/0", done_cnt - d0, err_cnt - e0);
        end
        obs_q.delete(); slave_dat_q.delete(); rd_got_q.delete();
        slave_dat_q = '{32'hBEEF_0001, 32'hBEEF_0002};
        exp_rd_q    = '{32'hBEEF_0001, 32'hBEEF_0002};
        exp_q.push_back(mk_beat(32'h3000_0000, 1'b0, 32'h0));
        exp_q.push_back(mk_beat(32'h3000_0004, 1'b0, 32'h0));
        issue_cmd(1'b0, 32'h3000_0000, 8'd2);
        run_xfer(1, 1, 100, ncyc, ok, de, ee, re);
        n_cmp++;
        if (!ok || de !== 1'b1 || rd_got_q.size() != 2) begin
            n_err++;
            $display("FAIL rst_fresh_end ok=%0d done=%b reads=%0d want 1/1/2", ok, de, rd_got_q.size());
        end
        while (exp_rd_q.size() > 0 && rd_got_q.size() > 0) begin
            n_cmp++;
            if (rd_got_q[0] !== exp_rd_q[0]) begin
                n_err++;
                $display("FAIL rst_fresh_data got=%h want=%h", rd_got_q[0], exp_rd_q[0]);
            end
            void'(rd_got_q.pop_front());
            void'(exp_rd_q.pop_front());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL rst_fresh_beat got=%h want=%h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete(); exp_rd_q.delete(); rd_got_q.delete();
        $display("test_reset_mid_read cycles=%0d", ncyc);
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_backpressure();
        test_write_gapped();
        test_timeout();
        test_len_zero();
        test_addr_wrap();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
